// File: rtl/adder_chk_pkg.sv
// Shared types and width helpers for the exhaustive adder checker.
package adder_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Vector index width: a and b interleaved, plus cin on top.
    function automatic int unsigned vec_width(input int unsigned width);
        return 2 * width + 1;
    endfunction

    // Mismatch counter width: wide enough to hold 2**vec_width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/adder_exhaustive_checker_if.sv
// Operand/result bus between the checker and the adder under test.
interface adder_exhaustive_checker_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_cin;
    logic [WIDTH-1:0] dut_s;
    logic             dut_cout;

    modport master (
        output dut_a, dut_b, dut_cin,
        input  dut_s, dut_cout
    );

    modport slave (
        input  dut_a, dut_b, dut_cin,
        output dut_s, dut_cout
    );
endinterface

// File: rtl/adder_vec_unpack.sv
// De-interleaves a vector index into adder operands: v[2k]=a[k], v[2k+1]=b[k], top bit=cin.
module adder_vec_unpack
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [vec_width(WIDTH)-1:0] v,
    output logic [WIDTH-1:0]            a,
    output logic [WIDTH-1:0]            b,
    output logic                        cin
);

    // Pure wiring: pick alternating bits for each operand.
    for (genvar k = 0; k < int'(WIDTH); k++) begin : g_bit
        assign a[k] = v[2*k];
        assign b[k] = v[2*k+1];
    end

    assign cin = v[2*WIDTH];

endmodule

// File: rtl/adder_exhaustive_checker.sv
// Sweeps every (a, b, cin) into an adder, checks {cout,s} against a+b+cin,
// and reports the mismatch count and the first failing vector index.
module adder_exhaustive_checker
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    adder_exhaustive_checker_if.master  dut_if,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [cnt_width(WIDTH)-1:0] err_count,
    output logic                        first_fail_valid,
    output logic [vec_width(WIDTH)-1:0] first_fail_vec
);

    localparam int unsigned VW = vec_width(WIDTH);
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [VW-1:0] VEC_LAST    = '1;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [SW-1:0]   settle_cnt;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic            vec_cin;
    logic [RW-1:0]   expect_c;
    logic            mismatch_c;

    adder_vec_unpack #(.WIDTH(WIDTH)) u_unpack (
        .v   (vec),
        .a   (vec_a),
        .b   (vec_b),
        .cin (vec_cin)
    );

    // Operands are a fixed rearrangement of the registered vector index.
    assign dut_if.dut_a   = vec_a;
    assign dut_if.dut_b   = vec_b;
    assign dut_if.dut_cin = vec_cin;

    // Golden result and comparison against the adder under test.
    assign expect_c   = RW'(vec_a) + RW'(vec_b) + RW'(vec_cin);
    assign mismatch_c = ({dut_if.dut_cout, dut_if.dut_s} != expect_c);

    // Sweep controller: drive, settle, check, advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            vec              <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec              <= '0;
                        settle_cnt       <= SETTLE_LOAD;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        state            <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch_c) begin
                        err_count <= err_count + CW'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec;
                        end
                    end
                    if (vec == VEC_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch_c;
                        state <= ST_DONE;
                    end else begin
                        vec        <= vec + VW'(1);
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// Bench: two checkers (SETTLE=1 and SETTLE=3) sharing clk/rst/start, each wired to
// a behavioural adder with selectable faults, checked every cycle against a timing model.
module tb_adder_exhaustive_checker;

    localparam int W  = 4;
    localparam int NV = 512;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    bit     mon_on = 1'b0;
    int     fault_mode = 0;
    int     fault_a = 0;
    int     fault_b = 0;
    int     fault_bit = 0;
    longint cyc = 0;

    // Model state per checker instance.
    int     settle_of[2] = '{1, 3};
    longint e0[2];
    bit     active[2];
    int     pre[2][NV+1];
    int     first_mis[2];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural adder, optionally faulty.
    function automatic logic [4:0] adder_out(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin, input int mode,
                                             input int fa, input int fb, input int fbit);
        logic [4:0] r;
        r = 5'(a) + 5'(b) + 5'(cin);
        case (mode)
            1: r[0] = 1'b0;
            2: r[4] = 1'b0;
            3: if (int'(a) == fa && int'(b) == fb) r[fbit] = ~r[fbit];
            default: ;
        endcase
        return r;
    endfunction

    function automatic void split_vec(input int v, output int a, output int b, output int cin);
        a = 0;
        b = 0;
        for (int k = 0; k < W; k++) begin
            a |= ((v >> (2*k)) & 1) << k;
            b |= ((v >> (2*k+1)) & 1) << k;
        end
        cin = (v >> (2*W)) & 1;
    endfunction

    // Mismatch prefix counts for the fault active when a sweep is accepted.
    task automatic build_model(input int i);
        int a, b, cin, ideal, got;
        pre[i][0]    = 0;
        first_mis[i] = NV;
        for (int v = 0; v < NV; v++) begin
            split_vec(v, a, b, cin);
            ideal = a + b + cin;
            got   = int'(adder_out(4'(a), 4'(b), 1'(cin), fault_mode, fault_a, fault_b, fault_bit));
            pre[i][v+1] = pre[i][v] + ((got != ideal) ? 1 : 0);
            if (got != ideal && first_mis[i] == NV) first_mis[i] = v;
        end
    endtask

    // Expected {a,b,cin,busy,done,pass,err,ffv,ffvec} after the latest edge.
    function automatic logic [31:0] exp_status(input int i);
        longint t, tot;
        int m, v, a, b, cin, err, fvec;
        bit bsy, dn, ps, fv;
        if (!active[i]) return 32'd0;
        t   = cyc - e0[i];
        tot = longint'(NV * (settle_of[i] + 1));
        if (t < tot) begin
            m = int'(t / longint'(settle_of[i] + 1));
            v = m;  bsy = 1'b1; dn = 1'b0; ps = 1'b0;
        end else begin
            m = NV; v = NV - 1; bsy = 1'b0; dn = 1'b1; ps = (pre[i][NV] == 0);
        end
        err  = pre[i][m];
        fv   = (first_mis[i] < m);
        fvec = fv ? first_mis[i] : 0;
        split_vec(v, a, b, cin);
        return {4'(a), 4'(b), 1'(cin), bsy, dn, ps, 10'(err), fv, 9'(fvec)};
    endfunction

    // Model update on each active edge: reset wins, start accepted only when not sweeping.
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                active[i] = 1'b0;
            end else if (start &&
                         !(active[i] && (cyc - e0[i]) <= longint'(NV * (settle_of[i] + 1)))) begin
                e0[i]     = cyc;
                active[i] = 1'b1;
                build_model(i);
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned S = (g == 0) ? 1 : 3;
        adder_exhaustive_checker_if #(.WIDTH(W)) bus ();
        logic       busy_w, done_w, pass_w, ffv_w;
        logic [9:0] err_w;
        logic [8:0] ffvec_w;
        logic [31:0] act;

        assign {bus.dut_cout, bus.dut_s} = adder_out(bus.dut_a, bus.dut_b, bus.dut_cin,
                                                     fault_mode, fault_a, fault_b, fault_bit);

        adder_exhaustive_checker #(.WIDTH(W), .SETTLE(S)) u_dut (
            .clk              (clk),
            .rst              (rst),
            .start            (start),
            .dut_if           (bus),
            .busy             (busy_w),
            .done             (done_w),
            .pass             (pass_w),
            .err_count        (err_w),
            .first_fail_valid (ffv_w),
            .first_fail_vec   (ffvec_w)
        );

        assign act = {bus.dut_a, bus.dut_b, bus.dut_cin, busy_w, done_w, pass_w,
                      err_w, ffv_w, ffvec_w};

        // Cycle-by-cycle comparison against the model.
        initial forever begin
            @(negedge clk);
            if (mon_on) chk($sformatf("status_s%0d", S), longint'(act), longint'(exp_status(g)));
        end
    end

    // Wait for both sweeps to finish; optionally sprinkle ignored start pulses while busy.
    task automatic wait_done(input bit noise, output longint t0, output longint t1);
        t0 = -1;
        t1 = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (t0 < 0 && g_inst[0].done_w) t0 = cyc - e0[0];
            if (t1 < 0 && g_inst[1].done_w) t1 = cyc - e0[1];
            if (t0 >= 0 && t1 >= 0) break;
            if (noise && g_inst[0].busy_w && g_inst[1].busy_w && $urandom_range(0, 39) == 0)
                start = 1'b1;
        end
        start = 1'b0;
        chk("sweep_timeout", longint'(t0 >= 0 && t1 >= 0), 1);
    endtask

    task automatic run_sweep(input int mode, input bit noise, output longint t0, output longint t1);
        fault_mode = mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(noise, t0, t1);
    endtask

    longint t0, t1, e0_keep;
    int ra, rb, rc;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;

        // Reset state.
        chk("rst_busy", g_inst[0].busy_w, 0);
        chk("rst_done", g_inst[0].done_w, 0);
        chk("rst_err", g_inst[0].err_w, 0);
        chk("rst_ops", g_inst[1].act, 0);

        // Correct adder.
        run_sweep(0, 1'b0, t0, t1);
        chk("done_time_s1", t0, 1024);
        chk("done_time_s3", t1, 2048);
        chk("good_pass", g_inst[0].pass_w, 1);
        chk("good_err", g_inst[0].err_w, 0);
        chk("good_ffv", g_inst[0].ffv_w, 0);
        chk("good_pass_s3", g_inst[1].pass_w, 1);

        // s[0] stuck at 0.
        run_sweep(1, 1'b0, t0, t1);
        chk("s0_err", g_inst[0].err_w, 256);
        chk("s0_first", g_inst[0].ffvec_w, 1);
        chk("s0_pass", g_inst[0].pass_w, 0);
        chk("s0_err_s3", g_inst[1].err_w, 256);

        // cout stuck at 0.
        run_sweep(2, 1'b0, t0, t1);
        chk("co_err", g_inst[0].err_w, 256);
        chk("co_first", g_inst[0].ffvec_w, 87);
        chk("co_first_s3", g_inst[1].ffvec_w, 87);

        // Random single-operand-pair bit flip, with start pulses while busy.
        fault_a   = int'($urandom_range(0, 15));
        fault_b   = int'($urandom_range(0, 15));
        fault_bit = int'($urandom_range(0, 4));
        fault_mode = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0_keep = e0[0];
        wait_done(1'b1, t0, t1);
        chk("rnd_no_restart", e0[0], e0_keep);
        chk("rnd_done_time", t0, 1024);
        chk("rnd_err", g_inst[0].err_w, 2);
        split_vec(int'(g_inst[0].ffvec_w), ra, rb, rc);
        chk("rnd_first_a", ra, fault_a);
        chk("rnd_first_b", rb, fault_b);
        chk("rnd_first_cin", rc, 0);

        // Reset mid-sweep of a faulty run, then rerun.
        fault_mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (298) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_s1", g_inst[0].act, 0);
        chk("midrst_s3", g_inst[1].act, 0);
        run_sweep(1, 1'b0, t0, t1);
        chk("rerun_err", g_inst[0].err_w, 256);
        chk("rerun_first", g_inst[0].ffvec_w, 1);

        // Start together with reset is dropped.
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", g_inst[0].busy_w, 0);
        chk("rst_start_done", g_inst[0].done_w, 0);

        // Start from DONE clears results and runs again.
        run_sweep(2, 1'b0, t0, t1);
        fault_mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("redo_err_clr", g_inst[0].err_w, 0);
        chk("redo_busy", g_inst[0].busy_w, 1);
        chk("redo_done_clr", g_inst[0].done_w, 0);
        wait_done(1'b0, t0, t1);
        chk("redo_pass", g_inst[0].pass_w, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
